// File: rtl/usb_system_onchip_memory_arbiter.sv
// Two-master Avalon-MM arbiter for the single-port on-chip RAM.
// Arbitration is round-robin or fixed-priority, and read data returns with a fixed 1-cycle latency.
module usb_system_onchip_memory_arbiter #(
  parameter int ADDR_W         = 13,
  parameter int DATA_W         = 32,
  parameter int BE_W           = 4,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  master_e last_grant;
  master_e grant_id;
  master_e rd_id_q;
  logic    req0;
  logic    req1;
  logic    grant_any;
  logic    grant_rd;
  logic    rd_vld_q;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // No grant while reset is high, so a command presented in that cycle is never accepted.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = M0;
    if (!reset) begin
      if (req0 && req1) begin
        grant_any = 1'b1;
        if (FIXED_PRIORITY != 0) grant_id = M0;
        else                     grant_id = (last_grant == M0) ? M1 : M0;
      end else if (req0) begin
        grant_any = 1'b1;
        grant_id  = M0;
      end else if (req1) begin
        grant_any = 1'b1;
        grant_id  = M1;
      end
    end
  end

  // A read with write also asserted is treated as a write only.
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    grant_rd       = 1'b0;
    if (grant_any) begin
      mem_chipselect = 1'b1;
      if (grant_id == M0) begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_write      = m0_write;
        mem_writedata  = m0_writedata;
        grant_rd       = m0_read & ~m0_write;
      end else begin
        mem_address    = m1_address;
        mem_byteenable = m1_byteenable;
        mem_write      = m1_write;
        mem_writedata  = m1_writedata;
        grant_rd       = m1_read & ~m1_write;
      end
    end
  end

  assign m0_waitrequest = ~(grant_any && (grant_id == M0));
  assign m1_waitrequest = ~(grant_any && (grant_id == M1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_q   <= 1'b0;
      rd_id_q    <= M0;
      last_grant <= M1;
    end else begin
      rd_vld_q <= grant_rd;
      if (grant_any) begin
        last_grant <= grant_id;
        rd_id_q    <= grant_id;
      end
    end
  end

  assign m0_readdatavalid = rd_vld_q && (rd_id_q == M0);
  assign m1_readdatavalid = rd_vld_q && (rd_id_q == M1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign mem_clken        = 1'b1;

endmodule

// File: tb/tb_usb_system_onchip_memory_arbiter.sv
// Self-checking bench for usb_system_onchip_memory_arbiter.
// It runs a round-robin and a fixed-priority instance against a grant/latency reference model and a RAM model.
module tb_usb_system_onchip_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;

  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;

  logic        f_m0_waitrequest, f_m1_waitrequest, f_m0_readdatavalid, f_m1_readdatavalid;
  logic [31:0] f_m0_readdata, f_m1_readdata;
  logic [12:0] f_mem_address;
  logic [3:0]  f_mem_byteenable;
  logic        f_mem_chipselect, f_mem_write, f_mem_clken;
  logic [31:0] f_mem_writedata;
  logic [31:0] f_mem_readdata = '0;

  always #5 clk = ~clk;

  usb_system_onchip_memory_arbiter #(.FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset(rst),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  usb_system_onchip_memory_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(rst),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(f_m0_waitrequest),
    .m0_readdata(f_m0_readdata), .m0_readdatavalid(f_m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(f_m1_waitrequest),
    .m1_readdata(f_m1_readdata), .m1_readdatavalid(f_m1_readdatavalid),
    .mem_address(f_mem_address), .mem_byteenable(f_mem_byteenable), .mem_chipselect(f_mem_chipselect),
    .mem_write(f_mem_write), .mem_writedata(f_mem_writedata), .mem_clken(f_mem_clken),
    .mem_readdata(f_mem_readdata)
  );

  // Power-on contents of both the RAM model and the shadow memory.
  function automatic logic [31:0] init_word(input logic [12:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
  endfunction

  // RAM model: 1-cycle synchronous read, byte-lane writes committed at the edge.
  logic [31:0] ram [0:8191];
  bit          ram_wr [0:8191];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        if (!ram_wr[mem_address]) begin
          for (int b = 0; b < 4; b++)
            if (!mem_byteenable[b]) ram[mem_address][8*b +: 8] <= init_word(mem_address) >> (8*b);
        end
        ram_wr[mem_address] <= 1'b1;
      end else begin
        mem_readdata <= ram_wr[mem_address] ? ram[mem_address] : init_word(mem_address);
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [31:0] shadow [0:8191];
  int          m_last = 1;
  bit          pend_vld = 0;
  int          pend_id = 0;
  logic [31:0] pend_data = '0;
  bit          fpend_vld = 0;
  int          fpend_id = 0;
  int          cur_g = -1;
  logic        obs_w0, obs_w1, obs_fw1;

  function automatic int winner(input bit r0, input bit r1, input int last, input bit fp);
    if (r0 && r1) return fp ? 0 : 1 - last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // One clock cycle: compare all DUT outputs at the negedge, advance the model, then step the clock.
  task automatic cycle();
    bit r0, r1, gw, grd;
    int g, gf;
    logic [12:0] ga;
    logic [3:0]  gbe;
    logic [31:0] gd;
    @(negedge clk);
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    g  = rst ? -1 : winner(r0, r1, m_last, 1'b0);
    gf = rst ? -1 : winner(r0, r1, m_last, 1'b1);
    if (rst) begin
      pend_vld  = 0;
      fpend_vld = 0;
    end
    obs_w0 = m0_waitrequest; obs_w1 = m1_waitrequest; obs_fw1 = f_m1_waitrequest;

    check("m0_wait", 32'(m0_waitrequest), 32'(g != 0));
    check("m1_wait", 32'(m1_waitrequest), 32'(g != 1));
    check("fp_m0_wait", 32'(f_m0_waitrequest), 32'(gf != 0));
    check("fp_m1_wait", 32'(f_m1_waitrequest), 32'(gf != 1));
    check("clken", 32'(mem_clken & f_mem_clken), 32'(1));
    check("m0_rdv", 32'(m0_readdatavalid), 32'(pend_vld && pend_id == 0));
    check("m1_rdv", 32'(m1_readdatavalid), 32'(pend_vld && pend_id == 1));
    check("fp_m0_rdv", 32'(f_m0_readdatavalid), 32'(fpend_vld && fpend_id == 0));
    check("fp_m1_rdv", 32'(f_m1_readdatavalid), 32'(fpend_vld && fpend_id == 1));
    if (pend_vld && pend_id == 0) check("m0_rdata", m0_readdata, pend_data);
    if (pend_vld && pend_id == 1) check("m1_rdata", m1_readdata, pend_data);

    ga  = (g == 1) ? m1_address : m0_address;
    gbe = (g == 1) ? m1_byteenable : m0_byteenable;
    gd  = (g == 1) ? m1_writedata : m0_writedata;
    gw  = (g == 1) ? m1_write : m0_write;
    grd = ((g == 1) ? m1_read : m0_read) && !gw;
    check("mem_cs", 32'(mem_chipselect), 32'(g >= 0));
    check("mem_we", 32'(mem_write), 32'(g >= 0 && gw));
    check("mem_addr", 32'(mem_address), (g >= 0) ? 32'(ga) : 32'd0);
    check("mem_wdata", mem_writedata, (g >= 0) ? gd : 32'd0);
    if (g >= 0) check("mem_be", 32'(mem_byteenable), 32'(gbe));
    check("fp_mem_cs", 32'(f_mem_chipselect), 32'(gf >= 0));

    pend_vld  = 0;
    fpend_vld = 0;
    if (rst) m_last = 1;
    if (g >= 0) begin
      m_last = g;
      if (gw) begin
        for (int b = 0; b < 4; b++)
          if (gbe[b]) shadow[ga][8*b +: 8] = gd[8*b +: 8];
      end else if (grd) begin
        pend_vld  = 1;
        pend_id   = g;
        pend_data = shadow[ga];
      end
    end
    if (gf >= 0) begin
      fpend_vld = ((gf == 1) ? m1_read && !m1_write : m0_read && !m0_write);
      fpend_id  = gf;
    end
    cur_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input bit rd, input bit wr, input logic [12:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  task automatic idle_both();
    set_m(0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, '0, '0, '0);
  endtask

  bit          pv [2];
  bit          prd [2];
  bit          pwr [2];
  logic [12:0] pad [2];
  logic [3:0]  pbe [2];
  logic [31:0] pdt [2];
  int          cnt0, cnt1, fcnt;

  initial begin
    for (int i = 0; i < 8192; i++) shadow[i] = init_word(13'(i));

    // Reset state.
    cycle();
    cycle();
    check("rst_m0_wait", 32'(obs_w0), 32'(1));
    check("rst_m1_wait", 32'(obs_w1), 32'(1));
    rst = 1'b0;
    cycle();

    // Simultaneous reads after reset: m0 first, then m1.
    set_m(0, 1, 0, 13'h010, 4'hF, '0);
    set_m(1, 1, 0, 13'h020, 4'hF, '0);
    cycle();
    check("t1_first_m0", 32'(cur_g), 32'(0));
    check("t1_rdv0", 32'(m0_readdatavalid), 32'(1));
    check("t1_rdv1_lo", 32'(m1_readdatavalid), 32'(0));
    check("t1_data0", m0_readdata, init_word(13'h010));
    set_m(0, 0, 0, '0, '0, '0);
    cycle();
    check("t1_second_m1", 32'(cur_g), 32'(1));
    check("t1_rdv1", 32'(m1_readdatavalid), 32'(1));
    check("t1_rdv0_lo", 32'(m0_readdatavalid), 32'(0));
    check("t1_data1", m1_readdata, init_word(13'h020));
    idle_both();
    cycle();

    // Continuous reads from both masters for 8 cycles.
    cnt0 = 0; cnt1 = 0;
    set_m(0, 1, 0, 13'h100, 4'hF, '0);
    set_m(1, 1, 0, 13'h200, 4'hF, '0);
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (!obs_w0) begin cnt0++; m0_address = m0_address + 13'd1; end
      if (!obs_w1) begin cnt1++; m1_address = m1_address + 13'd1; end
    end
    check("t2_cnt0", 32'(cnt0), 32'(4));
    check("t2_cnt1", 32'(cnt1), 32'(4));
    idle_both();
    cycle();

    // Partial write at the top address over a cleared word, read back next cycle.
    set_m(0, 0, 1, 13'h1FFF, 4'hF, 32'h0);
    cycle();
    set_m(0, 0, 0, '0, '0, '0);
    set_m(1, 0, 1, 13'h1FFF, 4'b0101, 32'hDEADBEEF);
    cycle();
    set_m(1, 0, 0, '0, '0, '0);
    set_m(0, 1, 0, 13'h1FFF, 4'hF, '0);
    cycle();
    check("t3_rdv", 32'(m0_readdatavalid), 32'(1));
    check("t3_data", m0_readdata, 32'h00AD00EF);
    idle_both();
    cycle();

    // Fixed-priority instance: m0 wins every tie, then m1 takes over.
    fcnt = 0;
    set_m(0, 1, 0, 13'h030, 4'hF, '0);
    set_m(1, 1, 0, 13'h040, 4'hF, '0);
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (obs_fw1) fcnt++;
    end
    check("t4_fp_m1_held", 32'(fcnt), 32'(5));
    set_m(0, 0, 0, '0, '0, '0);
    cycle();
    check("t4_fp_m1_gnt", 32'(obs_fw1), 32'(0));
    idle_both();
    cycle();

    // Reset right after an accepted read suppresses its readdatavalid.
    set_m(0, 1, 0, 13'h050, 4'hF, '0);
    cycle();
    check("t5_accepted", 32'(cur_g), 32'(0));
    rst = 1'b1;
    set_m(1, 1, 0, 13'h060, 4'hF, '0);
    cycle();
    check("t5_rdv_lo", 32'(m0_readdatavalid), 32'(0));
    rst = 1'b0;
    cycle();
    check("t5_tie_m0", 32'(obs_w0), 32'(0));
    idle_both();
    cycle();

    // Read and write together act as a write.
    set_m(0, 1, 1, 13'h0004, 4'hF, 32'h12345678);
    cycle();
    check("t6_no_rdv", 32'(m0_readdatavalid), 32'(0));
    set_m(0, 1, 0, 13'h0004, 4'hF, '0);
    cycle();
    check("t6_data", m0_readdata, 32'h12345678);
    idle_both();
    cycle();

    // Randomized traffic; masters hold commands until the model grants them.
    for (int m = 0; m < 2; m++) pv[m] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pv[m] && $urandom_range(0, 9) < 6) begin
          int k;
          pv[m]  = 1;
          k      = $urandom_range(0, 5);
          prd[m] = (k != 0);
          pwr[m] = (k <= 2);
          pad[m] = ($urandom_range(0, 4) == 0) ? 13'(13'h1FFF - 13'($urandom_range(0, 1)))
                                               : 13'($urandom_range(0, 15));
          pbe[m] = 4'($urandom_range(0, 15));
          pdt[m] = $urandom;
        end
        if (pv[m]) set_m(m, prd[m], pwr[m], pad[m], pbe[m], pdt[m]);
        else       set_m(m, 0, 0, 13'($urandom), 4'($urandom), $urandom);
      end
      if (c == 200) rst = 1'b1;
      if (c == 202) rst = 1'b0;
      cycle();
      if (cur_g >= 0) pv[cur_g] = 0;
    end
    idle_both();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
